// File: rtl/box_plotter.sv
// Pixel burst sequencer: paints one CELL x CELL box per request through the VGA plot port.
// Serves erase/draw requests (erase first), then pulses the matching done output once.
module box_plotter #(
  parameter int          CELL         = 4,
  parameter int          X_OFFSET     = 8,
  parameter int          Y_OFFSET     = 0,
  parameter logic [2:0]  DRAW_COLOUR  = 3'b100,
  parameter logic [2:0]  ERASE_COLOUR = 3'b111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       drawBox,
  input  logic       eraseBox,
  input  logic [4:0] drawX,
  input  logic [4:0] drawY,
  input  logic [4:0] prevX,
  input  logic [4:0] prevY,
  output logic [7:0] vgaX,
  output logic [6:0] vgaY,
  output logic [2:0] colour,
  output logic       plot,
  output logic       doneDraw,
  output logic       doneErase,
  output logic [2:0] debug_state
);

  localparam int             CW   = $clog2(CELL);
  localparam logic [CW-1:0]  LAST = CW'(CELL - 1);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] PLOT = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] HOLD = 3'd4;

  logic [2:0]    state;
  logic          op_erase;
  logic [8:0]    base_x;
  logic [8:0]    base_y;
  logic [CW-1:0] col;
  logic [CW-1:0] row;

  logic [4:0]    cx;
  logic [4:0]    cy;
  logic [8:0]    load_x;
  logic [8:0]    load_y;
  logic [CW-1:0] next_col;
  logic [CW-1:0] next_row;
  logic [8:0]    px;
  logic [8:0]    py;
  logic          visible;
  logic          last_pixel;
  logic          served_req;
  logic [2:0]    op_colour;

  // px/py is the pixel that will be presented on the outputs after the next edge:
  // pixel (0,0) straight from the inputs in LOAD, the successor of (col,row) in PLOT.
  always_comb begin
    cx         = op_erase ? prevX : drawX;
    cy         = op_erase ? prevY : drawY;
    load_x     = 9'(X_OFFSET) + ({4'd0, cx} << CW);
    load_y     = 9'(Y_OFFSET) + ({4'd0, cy} << CW);
    next_col   = col + 1'b1;
    next_row   = (col == LAST) ? row + 1'b1 : row;
    last_pixel = (col == LAST) && (row == LAST);
    if (state == LOAD) begin
      px = load_x;
      py = load_y;
    end else begin
      px = base_x + 9'(next_col);
      py = base_y + 9'(next_row);
    end
    visible    = (px <= 9'd159) && (py <= 9'd119);
    op_colour  = op_erase ? ERASE_COLOUR : DRAW_COLOUR;
    served_req = op_erase ? eraseBox : drawBox;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      op_erase  <= 1'b0;
      base_x    <= 9'd0;
      base_y    <= 9'd0;
      col       <= '0;
      row       <= '0;
      vgaX      <= 8'd0;
      vgaY      <= 7'd0;
      colour    <= 3'd0;
      plot      <= 1'b0;
      doneDraw  <= 1'b0;
      doneErase <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (eraseBox) begin
            op_erase <= 1'b1;
            state    <= LOAD;
          end else if (drawBox) begin
            op_erase <= 1'b0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          base_x <= load_x;
          base_y <= load_y;
          col    <= '0;
          row    <= '0;
          plot   <= visible;
          if (visible) begin
            vgaX   <= px[7:0];
            vgaY   <= py[6:0];
            colour <= op_colour;
          end
          state <= PLOT;
        end
        PLOT: begin
          if (last_pixel) begin
            plot      <= 1'b0;
            doneErase <= op_erase;
            doneDraw  <= ~op_erase;
            state     <= DONE;
          end else begin
            // Clipped pixels still consume a cycle so every burst has the same length.
            col  <= next_col;
            row  <= next_row;
            plot <= visible;
            if (visible) begin
              vgaX   <= px[7:0];
              vgaY   <= py[6:0];
              colour <= op_colour;
            end
          end
        end
        DONE: begin
          doneDraw  <= 1'b0;
          doneErase <= 1'b0;
          state     <= HOLD;
        end
        HOLD: begin
          if (!served_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign debug_state = state;

endmodule

// File: tb/tb_box_plotter.sv
// Bench for box_plotter: directed scenarios plus random bursts, each checked cycle by cycle
// against a per-pixel model of the box built from cell coordinates.
module tb_box_plotter;

  localparam int         CELL  = 4;
  localparam int         X_OFF = 8;
  localparam int         Y_OFF = 0;
  localparam logic [2:0] DC    = 3'b100;
  localparam logic [2:0] EC    = 3'b111;
  localparam int         NPIX  = CELL * CELL;

  logic       clock;
  logic       reset;
  logic       drawBox;
  logic       eraseBox;
  logic [4:0] drawX;
  logic [4:0] drawY;
  logic [4:0] prevX;
  logic [4:0] prevY;
  logic [7:0] vgaX;
  logic [6:0] vgaY;
  logic [2:0] colour;
  logic       plot;
  logic       doneDraw;
  logic       doneErase;
  logic [2:0] debug_state;

  int n_checks = 0;
  int n_pass   = 0;

  logic [17:0] exp_q[$];
  bit          exp_vis[NPIX];

  box_plotter dut (
    .clock(clock), .reset(reset), .drawBox(drawBox), .eraseBox(eraseBox),
    .drawX(drawX), .drawY(drawY), .prevX(prevX), .prevY(prevY),
    .vgaX(vgaX), .vgaY(vgaY), .colour(colour), .plot(plot),
    .doneDraw(doneDraw), .doneErase(doneErase), .debug_state(debug_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference: the box covers CELL x CELL pixels from the cell's corner, raster order,
  // and any pixel off the 160x120 screen is not written.
  task automatic model_burst(input bit erase, input int cx, input int cy);
    int x;
    int y;
    exp_q.delete();
    for (int r = 0; r < CELL; r++) begin
      for (int c = 0; c < CELL; c++) begin
        x = X_OFF + cx * CELL + c;
        y = Y_OFF + cy * CELL + r;
        exp_vis[r * CELL + c] = (x <= 159) && (y <= 119);
        if (exp_vis[r * CELL + c]) exp_q.push_back({8'(x), 7'(y), erase ? EC : DC});
      end
    end
  endtask

  // Cycle 0 is the cycle in which the request is raised while the block is idle.
  task automatic run_burst(input bit erase, input logic [4:0] cx, input logic [4:0] cy,
                           input int hold_extra, input bit scramble, input bit skip_sync);
    logic [17:0] e;
    int last;
    last = NPIX + 2;
    if (!skip_sync) begin
      @(posedge clock);
      #1;
    end
    if (erase) begin
      eraseBox = 1'b1; prevX = cx; prevY = cy;
    end else begin
      drawBox = 1'b1; drawX = cx; drawY = cy;
    end
    model_burst(erase, int'(cx), int'(cy));
    for (int n = 0; n <= last; n++) begin
      @(negedge clock);
      if (n >= 2 && n < last) begin
        check("plot", {31'd0, plot}, {31'd0, exp_vis[n - 2]});
        if (plot && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("pixel", {14'd0, vgaX, vgaY, colour}, {14'd0, e});
        end
        if (scramble) begin
          if (erase) begin
            prevX = 5'($urandom_range(0, 31)); prevY = 5'($urandom_range(0, 31));
          end else begin
            drawX = 5'($urandom_range(0, 31)); drawY = 5'($urandom_range(0, 31));
          end
        end
      end else begin
        check("plot_off", {31'd0, plot}, 32'd0);
      end
      check("doneDraw", {31'd0, doneDraw}, {31'd0, (n == last) && !erase});
      check("doneErase", {31'd0, doneErase}, {31'd0, (n == last) && erase});
    end
    check("q_empty", exp_q.size(), 32'd0);
    repeat (hold_extra) begin
      @(negedge clock);
      check("hold_quiet", {29'd0, plot, doneDraw, doneErase}, 32'd0);
    end
    @(posedge clock);
    #1;
    if (erase) eraseBox = 1'b0;
    else drawBox = 1'b0;
    @(negedge clock);
    check("release_quiet", {29'd0, plot, doneDraw, doneErase}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; drawBox = 1'b0; eraseBox = 1'b0;
    drawX = 5'd0; drawY = 5'd0; prevX = 5'd0; prevY = 5'd0;
    repeat (2) @(negedge clock);
    check("reset_outputs", {11'd0, vgaX, vgaY, colour, plot, doneDraw, doneErase}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    run_burst(1'b0, 5'd1, 5'd0, 0, 1'b0, 1'b0);
    run_burst(1'b1, 5'd2, 5'd3, 1, 1'b0, 1'b0);

    // both requests at once: erase first, draw served after erase is released
    @(posedge clock);
    #1;
    drawBox = 1'b1; drawX = 5'd6; drawY = 5'd7;
    run_burst(1'b1, 5'd4, 5'd5, 3, 1'b0, 1'b1);
    run_burst(1'b0, 5'd6, 5'd7, 0, 1'b0, 1'b0);

    run_burst(1'b0, 5'd5, 5'd31, 0, 1'b0, 1'b0);
    run_burst(1'b0, 5'd31, 5'd29, 0, 1'b0, 1'b0);

    // reset during pixel 7 (cycle 9) of a draw at (3,4)
    @(posedge clock);
    #1;
    drawBox = 1'b1; drawX = 5'd3; drawY = 5'd4;
    repeat (10) @(negedge clock);
    check("mid_plot", {31'd0, plot}, 32'd1);
    check("mid_pixel", {14'd0, vgaX, vgaY, colour}, {14'd0, 8'd23, 7'd17, DC});
    #1;
    reset = 1'b1;
    #1;
    check("async_reset", {11'd0, vgaX, vgaY, colour, plot, doneDraw, doneErase}, 32'd0);
    repeat (3) begin
      @(negedge clock);
      check("reset_quiet", {29'd0, plot, doneDraw, doneErase}, 32'd0);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    run_burst(1'b0, 5'd3, 5'd4, 0, 1'b0, 1'b1);

    run_burst(1'b0, 5'd1, 5'd0, 0, 1'b1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_burst(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/box_plotter.md
# box_plotter

Pixel engine directly downstream of the game-logic handshake. It turns the `drawBox` / `eraseBox` requests and their 5-bit maze-cell coordinates into a burst of single-pixel writes to the VGA adapter's plot port. When a burst finishes it returns a one-cycle `doneDraw` / `doneErase` pulse to the position controller. The block owns no frame memory: it only sequences x/y/colour/plot.

## Interface
- `CELL`, default 4: box edge in pixels; a burst is `CELL*CELL` pixels. Legal values are 2, 4 and 8.
- `X_OFFSET`, default 8: pixel x of cell column 0.
- `Y_OFFSET`, default 0: pixel y of cell row 0.
- `DRAW_COLOUR`, default 3'b100: colour of the player box.
- `ERASE_COLOUR`, default 3'b111: colour of the maze floor.
- `clock` input 1: single system clock; all logic is on the rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `drawBox` input 1: level request to paint the box at `drawX`/`drawY`.
- `eraseBox` input 1: level request to paint the floor at `prevX`/`prevY`.
- `drawX`, `drawY` input 5 each: cell coordinates for draw.
- `prevX`, `prevY` input 5 each: cell coordinates for erase.
- `vgaX` output 8: pixel x.
- `vgaY` output 7: pixel y.
- `colour` output 3: pixel colour.
- `plot` output 1: write strobe; `vgaX`/`vgaY`/`colour` are valid whenever it is high.
- `doneDraw`, `doneErase` output 1 each: one-cycle completion pulses.

## Operation
- States are IDLE, LOAD, PLOT, DONE and HOLD.
- **IDLE**
  - If `eraseBox` is high: latch op=erase and go to LOAD. Erase has priority.
  - Else if `drawBox` is high: latch op=draw and go to LOAD.
- **LOAD**
  - Register the base pixel: `baseX = X_OFFSET + cx*CELL`, `baseY = Y_OFFSET + cy*CELL`.
  - `cx`/`cy` are sampled in this cycle: `prevX`/`prevY` for erase, `drawX`/`drawY` for draw.
  - Clear the column and row counters. Go to PLOT.
- **PLOT**
  - One pixel per cycle in raster order: column counter runs fastest, row counter slowest.
  - `vgaX = baseX + col`, `vgaY = baseY + row`, `colour` per the latched op.
  - After pixel (CELL-1, CELL-1), go to DONE.
- **DONE**
  - Assert `doneDraw` or `doneErase` (per op) for exactly one cycle. Go to HOLD.
- **HOLD**
  - Stay while the request that was served is still high.
  - When it is low, go to IDLE.
  - A request of the other type pending during HOLD is served from IDLE afterwards; it is never lost.
- **Width rules**
  - Base arithmetic is 9 bits wide.
  - Clipping: if `baseX + col > 159` or `baseY + row > 119`, hold `plot` low for that pixel.
  - Counters still advance on clipped pixels, so burst length is constant.
  - Truncate `vgaX`/`vgaY` to 8 and 7 bits.
- Input coordinate changes after LOAD do not affect the burst in progress.
- Requests that rise during LOAD, PLOT or DONE are neither queued nor restarted; only the level seen in IDLE matters.

## Timing
- Reset values: state IDLE; `plot`, `doneDraw`, `doneErase`, `vgaX`, `vgaY`, `colour` all 0; counters 0.
- Reset asserted mid-burst aborts it immediately.
  - No done pulse is issued.
  - After release the block samples requests fresh in IDLE.
- Let request-seen-in-IDLE be cycle 0:
  - LOAD is cycle 1.
  - Pixels are on cycles 2 … CELL²+1.
  - The done pulse is on cycle CELL²+2.
  - HOLD is entered on cycle CELL²+3.
- Outputs are registered. `plot` and its x/y/colour change together on the same edge.
- `plot` is 0 outside PLOT. `vgaX`/`vgaY`/`colour` hold their last value when `plot` is low.
- Minimum spacing between two bursts is CELL²+4 cycles: through HOLD with an immediate release, plus one IDLE cycle.

## Test plan
- Draw at (1,0), defaults
  - `drawBox` high → 16 plots.
  - Pixels are x 12..15 × y 0..3 in raster order, colour 3'b100.
  - `doneDraw` is a single pulse on cycle 18.
  - Drop `drawBox` → back to IDLE.
- Erase at (2,3)
  - `eraseBox` → 16 plots at x 16..19, y 12..15, colour 3'b111.
  - `doneErase` pulse; `doneDraw` stays 0.
- Simultaneous requests
  - `eraseBox` and `drawBox` both high in IDLE.
  - Erase burst runs first; hold `eraseBox` for 3 cycles past its done pulse.
  - Draw burst then starts; `doneErase` then `doneDraw`, each pulsing exactly once.
- Clipping at (5,31)
  - baseY is 124, so all 16 pixels are clipped: `plot` never high.
  - `doneDraw` still arrives on cycle 18.
  - Also at (31,29): x 132..135 and y 116..119 are in range, so 16 plots.
- Reset mid-burst
  - Assert `reset` at pixel 7 → outputs go to 0 asynchronously and no done pulse is issued.
  - Release with `drawBox` held → full 16-pixel burst restarts from pixel (0,0).
- Coordinate change mid-burst
  - Change `drawX` from 1 to 9 during PLOT → all pixels remain at x 12..15.
